// File: rtl/sum_frame_serializer.sv
// Captures one frame of 4-bit group counts and streams it out one count per beat.
// Latency: first beat 1 cycle after frame accept, totals pulse 1 cycle after the last beat.
// Backpressure: sum_ready low holds the current beat stable; frame_ready is high only in IDLE.
//
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   frame_valid / frame_ready     frame capture handshake; Input sampled only at accept
//   Input                         packed counts, group k at [4k+3:4k]
//   sum_valid / sum_ready         beat handshake for sum_data, sum_index, sum_last
//   total_valid                   one-cycle pulse when the frame results below update
//   frame_total, peak_value,      frame sum (mod 2^TW), largest count, first index of it,
//   peak_index, range_err         and a flag for any count above 8
module sum_frame_serializer #(
  parameter int SAMPLES = 128,
  parameter int OSF     = 8,
  localparam int FW = (SAMPLES * OSF) / 2,
  localparam int N  = (SAMPLES * OSF) / 8,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int TW = $clog2(SAMPLES * OSF + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_valid,
  output logic          frame_ready,
  input  logic [FW-1:0] Input,
  output logic          sum_valid,
  input  logic          sum_ready,
  output logic [3:0]    sum_data,
  output logic [IW-1:0] sum_index,
  output logic          sum_last,
  output logic          total_valid,
  output logic [TW-1:0] frame_total,
  output logic [3:0]    peak_value,
  output logic [IW-1:0] peak_index,
  output logic          range_err
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t        state;
  logic [FW-1:0] frame_q;
  logic [IW-1:0] idx;
  logic [TW-1:0] acc;
  logic [3:0]    run_peak;
  logic [IW-1:0] run_idx;
  logic          run_err;

  // Running results including the beat currently presented, so the final
  // beat's contribution can be committed on the same edge that accepts it.
  logic [3:0]    cur_dat;
  logic          last_beat;
  logic          peak_hit;
  logic [TW-1:0] nxt_acc;
  logic [3:0]    nxt_peak;
  logic [IW-1:0] nxt_pidx;
  logic          nxt_err;
  logic          beat_fire;

  always_comb begin
    cur_dat   = frame_q[{idx, 2'b00} +: 4];
    last_beat = (idx == IW'(N - 1));
    peak_hit  = (cur_dat > run_peak);  // strict: ties keep the earliest index
    nxt_acc   = acc + TW'(cur_dat);
    nxt_peak  = peak_hit ? cur_dat : run_peak;
    nxt_pidx  = peak_hit ? idx : run_idx;
    nxt_err   = run_err | (cur_dat > 4'd8);
    beat_fire = sum_valid & sum_ready;
  end

  // Beat outputs are forced to zero outside STREAM so idle/reset look clean.
  assign sum_data  = sum_valid ? cur_dat : 4'd0;
  assign sum_index = sum_valid ? idx : '0;
  assign sum_last  = sum_valid & last_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      frame_ready <= 1'b1;
      sum_valid   <= 1'b0;
      total_valid <= 1'b0;
      frame_q     <= '0;
      idx         <= '0;
      acc         <= '0;
      run_peak    <= 4'd0;
      run_idx     <= '0;
      run_err     <= 1'b0;
      frame_total <= '0;
      peak_value  <= 4'd0;
      peak_index  <= '0;
      range_err   <= 1'b0;
    end else begin
      total_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (frame_valid) begin
            frame_q     <= Input;
            idx         <= '0;
            acc         <= '0;
            run_peak    <= 4'd0;
            run_idx     <= '0;
            run_err     <= 1'b0;
            frame_ready <= 1'b0;
            sum_valid   <= 1'b1;
            state       <= STREAM;
          end
        end
        STREAM: begin
          if (beat_fire) begin
            acc      <= nxt_acc;
            run_peak <= nxt_peak;
            run_idx  <= nxt_pidx;
            run_err  <= nxt_err;
            if (last_beat) begin
              // Results are published here so they are visible during DONE.
              idx         <= '0;
              sum_valid   <= 1'b0;
              total_valid <= 1'b1;
              frame_total <= nxt_acc;
              peak_value  <= nxt_peak;
              peak_index  <= nxt_pidx;
              range_err   <= nxt_err;
              state       <= DONE;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          frame_ready <= 1'b1;
          state       <= IDLE;
        end
        default: begin
          frame_ready <= 1'b1;
          sum_valid   <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_frame_serializer.sv
// Self-checking bench: scoreboard of expected beats and frame results, filled
// when a frame is driven and drained as the serializer produces output.
module tb_sum_frame_serializer;

  localparam int SAMPLES = 128;
  localparam int OSF     = 8;
  localparam int W       = SAMPLES * OSF / 2;
  localparam int N       = SAMPLES * OSF / 8;
  localparam int IW      = 7;
  localparam int TW      = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_valid = 1'b0;
  logic          frame_ready;
  logic [W-1:0]  Input = '0;
  logic          sum_valid;
  logic          sum_ready = 1'b1;
  logic [3:0]    sum_data;
  logic [IW-1:0] sum_index;
  logic          sum_last;
  logic          total_valid;
  logic [TW-1:0] frame_total;
  logic [3:0]    peak_value;
  logic [IW-1:0] peak_index;
  logic          range_err;

  sum_frame_serializer #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .clk(clk), .rst(rst),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .Input(Input),
    .sum_valid(sum_valid), .sum_ready(sum_ready), .sum_data(sum_data),
    .sum_index(sum_index), .sum_last(sum_last),
    .total_valid(total_valid), .frame_total(frame_total),
    .peak_value(peak_value), .peak_index(peak_index), .range_err(range_err)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int i; int l; } beat_t;
  typedef struct { int tot; int pk; int pi; int er; } res_t;

  beat_t beat_q[$];
  res_t  tot_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int done_cyc = 0;
  int beats    = 0;
  bit toggle_mode = 1'b0;
  bit latency_on  = 1'b1;
  bit stall_prev  = 1'b0;
  int hold_val    = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_frame_ready"}, int'(frame_ready), 1);
    check({tag, "_sum_valid"},   int'(sum_valid),   0);
    check({tag, "_sum_data"},    int'(sum_data),    0);
    check({tag, "_sum_last"},    int'(sum_last),    0);
    check({tag, "_total_valid"}, int'(total_valid), 0);
    check({tag, "_frame_total"}, int'(frame_total), 0);
    check({tag, "_peak"},        int'(peak_value),  0);
    check({tag, "_range_err"},   int'(range_err),   0);
  endtask

  function automatic logic [W-1:0] make_frame(input int kind);
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) begin
      case (kind)
        1:       v[4*k +: 4] = 4'(k % 9);
        2:       v[4*k +: 4] = 4'd8;
        3:       v[4*k +: 4] = (k == 5) ? 4'hF : 4'd0;
        default: v[4*k +: 4] = 4'd0;
      endcase
    end
    return v;
  endfunction

  // Cycle counter and sum_ready pattern (1,0,1,0... when toggling).
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    sum_ready = toggle_mode ? ~sum_ready : 1'b1;
  end

  // Output monitor, sampling on the falling edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      beats      = 0;
      stall_prev = 1'b0;
    end else begin
      if (frame_valid && frame_ready) acc_cyc = cyc;
      if (stall_prev)
        check("stall_hold", int'({sum_valid, sum_data, sum_index, sum_last}), hold_val);
      stall_prev = sum_valid && !sum_ready;
      hold_val   = int'({sum_valid, sum_data, sum_index, sum_last});
      if (sum_valid && sum_ready) begin
        if (beat_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          check("sum_data",  int'(sum_data),  b.d);
          check("sum_index", int'(sum_index), b.i);
          check("sum_last",  int'(sum_last),  b.l);
          if (latency_on && b.i == 0) check("first_beat_lat", cyc - acc_cyc, 1);
        end
        beats++;
      end
      if (total_valid) begin
        done_cyc = cyc;
        check("beat_count", beats, N);
        beats = 0;
        if (latency_on) check("total_lat", cyc - acc_cyc, N + 1);
        if (tot_q.size() == 0) begin
          check("total_unexpected", 1, 0);
        end else begin
          res_t r;
          r = tot_q.pop_front();
          check("frame_total", int'(frame_total), r.tot);
          check("peak_value",  int'(peak_value),  r.pk);
          check("peak_index",  int'(peak_index),  r.pi);
          check("range_err",   int'(range_err),   r.er);
        end
      end
    end
  end

  task automatic send_frame(input logic [W-1:0] v, input bit tog, input bit junk,
                            input bit abort);
    res_t r;
    bit   ok;
    r = '{tot: 0, pk: 0, pi: 0, er: 0};
    for (int k = 0; k < N; k++) begin
      int c;
      c = int'(v[4*k +: 4]);
      beat_q.push_back('{d: c, i: k, l: int'(k == N - 1)});
      r.tot = (r.tot + c) % (1 << TW);
      if (c > r.pk) begin r.pk = c; r.pi = k; end
      if (c > 8) r.er = 1;
    end
    tot_q.push_back(r);
    toggle_mode = tog;
    latency_on  = !tog;

    @(posedge clk); #1;
    Input = v;
    frame_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = frame_ready;
    end
    if (!ok) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    if (junk) begin
      // New data offered mid-stream must be ignored.
      Input = '1;
      repeat (50) @(posedge clk);
      #1;
    end
    frame_valid = 1'b0;
    Input = '0;

    if (abort) begin
      ok = 1'b0;
      for (int i = 0; i < 500 && !ok; i++) begin
        @(negedge clk);
        ok = (beats >= 60);
      end
      if (!ok) check("abort_timeout", 0, 1);
      @(posedge clk); #1;
      rst = 1'b1;
      beat_q.delete();
      tot_q.delete();
      #1;
      check_idle_outputs("midrst");
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
    end else begin
      ok = 1'b0;
      for (int i = 0; i < 1000 && !ok; i++) begin
        @(negedge clk);
        ok = (tot_q.size() == 0) && frame_ready;
      end
      if (!ok) check("done_timeout", 0, 1);
      else if (latency_on) check("ready_lat", cyc - done_cyc, 1);
      check("beats_left", beat_q.size(), 0);
    end
    toggle_mode = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    send_frame(make_frame(0), 1'b0, 1'b0, 1'b0);  // all zero
    send_frame(make_frame(1), 1'b0, 1'b0, 1'b0);  // k%9
    send_frame(make_frame(2), 1'b0, 1'b0, 1'b0);  // all 8
    send_frame(make_frame(1), 1'b1, 1'b1, 1'b0);  // ramp with stalls and junk frame_valid
    send_frame(make_frame(3), 1'b0, 1'b0, 1'b0);  // single 0xF -> range_err
    send_frame(make_frame(1), 1'b0, 1'b0, 1'b0);  // clean frame clears range_err
    send_frame(make_frame(2), 1'b0, 1'b0, 1'b1);  // reset at beat 60
    repeat (5) @(posedge clk);
    send_frame(make_frame(2), 1'b0, 1'b0, 1'b0);  // completes normally after reset

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
